// File: rtl/toy_bus_pkg.sv
// Shared toy-bus constants: payload widths, field offsets, arbiter lock state.
// Request payload: addr|strb|data|opcode|src_id|tgt_id|sideband, LSB first.
package toy_bus_pkg;

  localparam int TOY_BUS_REQ_PLD_W = 361;
  localparam int TOY_BUS_RSP_PLD_W = 297;

  localparam int ADDR_LSB = 0;
  localparam int STRB_LSB = 32;
  localparam int DATA_LSB = 64;
  localparam int OPC_LSB  = 320;
  localparam int SRC_LSB  = 321;
  localparam int TGT_LSB  = 325;
  localparam int SB_LSB   = 329;

  // Response payload drops addr and strb.
  localparam int RSP_DATA_LSB = 0;
  localparam int RSP_OPC_LSB  = 256;
  localparam int RSP_SRC_LSB  = 257;
  localparam int RSP_TGT_LSB  = 261;
  localparam int RSP_SB_LSB   = 265;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_st_e;

endpackage

// File: rtl/toy_bus_age_arb_pkt_if.sv
// N-to-1 arbitration bundle: per-requester vld/rdy/pld/last in, one channel out.
// slave = arbiter view, master = requesters plus downstream sink view.
interface toy_bus_age_arb_pkt_if
  import toy_bus_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int PLD_W  = TOY_BUS_REQ_PLD_W
);
  localparam int ID_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]       in_vld;
  logic [NUM_IN-1:0]       in_rdy;
  logic [NUM_IN*PLD_W-1:0] in_pld;
  logic [NUM_IN-1:0]       in_last;
  logic                    out_vld;
  logic                    out_rdy;
  logic [PLD_W-1:0]        out_pld;
  logic                    out_last;
  logic [ID_W-1:0]         out_gnt_id;

  modport master (
    output in_vld, in_pld, in_last, out_rdy,
    input  in_rdy, out_vld, out_pld, out_last, out_gnt_id
  );

  modport slave (
    input  in_vld, in_pld, in_last, out_rdy,
    output in_rdy, out_vld, out_pld, out_last, out_gnt_id
  );

endinterface

// File: rtl/toy_bus_age_mtx.sv
// N-wide age matrix: age_row[i][j]=1 means j is older than i; reset puts 0 oldest.
// Ports: clk, rst (async high), update_en (one-hot, makes that index youngest), age_row.
module toy_bus_age_mtx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] update_en,
  output logic [N-1:0] age_row [N]
);

  // Diagonal bits are never written and stay 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          age_row[i][j] <= 1'(j < i);
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (i != j) begin
            if (update_en[i])
              age_row[i][j] <= 1'b1;
            else if (update_en[j])
              age_row[i][j] <= 1'b0;
          end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = i + 1; j < N; j++) begin : g_c
      a_anti: assert property (@(posedge clk) disable iff (rst)
        age_row[i][j] ^ age_row[j][i]);
    end
  end

endmodule

// File: rtl/toy_bus_age_arb_pkt.sv
// Age-matrix N:1 arbiter with packet lock and stall lock; oldest valid wins.
// Ports: clk, rst (async high), bus (slave). Option: TOY_BUS_ARB_OUT_REG_EN.
module toy_bus_age_arb_pkt
  import toy_bus_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int PLD_W  = TOY_BUS_REQ_PLD_W
) (
  input logic                  clk,
  input logic                  rst,
  toy_bus_age_arb_pkt_if.slave bus
);

  localparam int ID_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0] age_row [NUM_IN];
  logic [NUM_IN-1:0] sel;
  logic [NUM_IN-1:0] gnt;
  logic [NUM_IN-1:0] upd;
  arb_st_e           st;
  logic [ID_W-1:0]   gnt_q;
  logic              rdy_int;
  logic              vld_c;
  logic              last_c;
  logic [PLD_W-1:0]  pld_c;
  logic [ID_W-1:0]   id_c;

  toy_bus_age_mtx #(.N(NUM_IN)) u_mtx (
    .clk       (clk),
    .rst       (rst),
    .update_en (upd),
    .age_row   (age_row)
  );

  always_comb begin
    for (int i = 0; i < NUM_IN; i++)
      sel[i] = bus.in_vld[i] & ~|(age_row[i] & bus.in_vld);
  end

  // Grant is forced to zero during reset so outputs read idle at once.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      unique case (st)
        ARB_LOCK: gnt[gnt_q] = 1'b1;
        default:  gnt = sel;
      endcase
    end
  end

  always_comb begin
    vld_c  = 1'b0;
    last_c = 1'b0;
    pld_c  = '0;
    id_c   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      vld_c  = vld_c  | (gnt[i] & bus.in_vld[i]);
      last_c = last_c | (gnt[i] & bus.in_vld[i] & bus.in_last[i]);
      pld_c  = pld_c  | ({PLD_W{gnt[i] & bus.in_vld[i]}}
                         & bus.in_pld[i*PLD_W +: PLD_W]);
      if (gnt[i])
        id_c = id_c | ID_W'(i);
    end
  end

  assign bus.in_rdy = gnt & {NUM_IN{rdy_int}};
  assign upd        = bus.in_vld & bus.in_rdy & bus.in_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= ARB_IDLE;
      gnt_q <= '0;
    end else begin
      unique case (st)
        ARB_IDLE:
          if (vld_c && (!rdy_int || !last_c)) begin
            st    <= ARB_LOCK;
            gnt_q <= id_c;
          end
        ARB_LOCK:
          if (vld_c && rdy_int && last_c)
            st <= ARB_IDLE;
        default:
          st <= ARB_IDLE;
      endcase
    end
  end

`ifdef TOY_BUS_ARB_OUT_REG_EN
  logic             full;
  logic [PLD_W-1:0] r_pld;
  logic             r_last;
  logic [ID_W-1:0]  r_id;

  assign rdy_int = ~full | bus.out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 1'b0;
      r_pld  <= '0;
      r_last <= 1'b0;
      r_id   <= '0;
    end else if (rdy_int) begin
      full   <= vld_c;
      r_pld  <= pld_c;
      r_last <= last_c;
      r_id   <= id_c;
    end
  end

  assign bus.out_vld    = full;
  assign bus.out_pld    = r_pld;
  assign bus.out_last   = r_last;
  assign bus.out_gnt_id = r_id;
`else
  assign rdy_int        = bus.out_rdy;
  assign bus.out_vld    = vld_c;
  assign bus.out_pld    = pld_c;
  assign bus.out_last   = last_c;
  assign bus.out_gnt_id = id_c;
`endif

  a_gnt: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt));

  a_stab: assert property (@(posedge clk) disable iff (rst)
    bus.out_vld && !bus.out_rdy |=> !bus.out_vld || $stable(bus.out_pld));

endmodule
